// File: rtl/alu_issue_if.sv
// Purpose: handshake and payload bundle between an instruction source, the
//          issue stage and the ALU, plus the register write-back port.
// Modports:
//   slave  - issue stage: consumes in_*/out_ready/wb_*, drives in_ready/out_*/illegal
//   master - surrounding logic: the mirror image of slave
interface alu_issue_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned RIDX = 5;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_x;
  logic [XLEN-1:0] out_y;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [RIDX-1:0] out_rd;
  logic            wb_valid;
  logic [RIDX-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            illegal;

  modport slave (
    input  in_valid, in_instr, out_ready, wb_valid, wb_rd, wb_data,
    output in_ready, out_valid, out_x, out_y, out_funct3, out_funct7, out_rd, illegal
  );

  modport master (
    output in_valid, in_instr, out_ready, wb_valid, wb_rd, wb_data,
    input  in_ready, out_valid, out_x, out_y, out_funct3, out_funct7, out_rd, illegal
  );
endinterface

// File: rtl/alu_issue.sv
// Purpose: decode RV32I OP / OP-IMM instructions, read operands from a
//          32x32 register file with write-back bypass, track outstanding
//          destinations with a busy scoreboard, and issue a registered ALU
//          operation. Non-issuable instructions are consumed and flagged.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - alu_issue_if.slave: instruction in (valid/ready), ALU
//                operation out (valid/ready), write-back, illegal pulse
module alu_issue (
  input logic        clk,
  input logic        rst_n,
  alu_issue_if.slave bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned RIDX = 5;

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Architectural state
  logic [XLEN-1:0] r_rf [NREG];
  logic [NREG-1:0] r_busy;

  // Output operation register
  logic            r_out_valid;
  logic [XLEN-1:0] r_out_x;
  logic [XLEN-1:0] r_out_y;
  logic [2:0]      r_out_funct3;
  logic [6:0]      r_out_funct7;
  logic [RIDX-1:0] r_out_rd;
  logic            r_illegal;

  // Instruction fields
  logic [6:0]      w_opc;
  logic [RIDX-1:0] w_rd;
  logic [2:0]      w_f3;
  logic [RIDX-1:0] w_rs1;
  logic [RIDX-1:0] w_rs2;
  logic [6:0]      w_f7_field;
  logic [XLEN-1:0] w_imm;

  assign w_opc      = bus.in_instr[6:0];
  assign w_rd       = bus.in_instr[11:7];
  assign w_f3       = bus.in_instr[14:12];
  assign w_rs1      = bus.in_instr[19:15];
  assign w_rs2      = bus.in_instr[24:20];
  assign w_f7_field = bus.in_instr[31:25];
  assign w_imm      = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};

  // Decode: legality, operand-y source and emitted funct7
  logic       w_is_op;
  logic       w_legal;
  logic [6:0] w_f7;

  always_comb begin
    w_is_op = 1'b0;
    w_legal = 1'b0;
    w_f7    = F7_ZERO;
    if (w_opc == OPC_OP) begin
      w_is_op = 1'b1;
      w_f7    = w_f7_field;
      w_legal = (w_f7_field == F7_ZERO) ||
                ((w_f7_field == F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
    end else if (w_opc == OPC_IMM) begin
      case (w_f3)
        3'b001:  w_legal = (w_f7_field == F7_ZERO);
        3'b101: begin
          w_legal = (w_f7_field == F7_ZERO) || (w_f7_field == F7_ALT);
          w_f7    = w_f7_field;
        end
        default: w_legal = 1'b1;
      endcase
    end
  end

  // A write-back in flight frees its register this cycle
  logic [NREG-1:0] w_clr;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_busy_eff;

  always_comb begin
    w_clr = '0;
    if (bus.wb_valid) w_clr[bus.wb_rd] = 1'b1;
  end

  assign w_busy_eff = r_busy & ~w_clr;

  // Operand read with same-cycle write-back bypass; x0 is hard zero
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic [XLEN-1:0] w_y;

  always_comb begin
    if (w_rs1 == '0)                             w_rs1_val = '0;
    else if (bus.wb_valid && (bus.wb_rd == w_rs1)) w_rs1_val = bus.wb_data;
    else                                         w_rs1_val = r_rf[w_rs1];
  end

  always_comb begin
    if (w_rs2 == '0)                             w_rs2_val = '0;
    else if (bus.wb_valid && (bus.wb_rd == w_rs2)) w_rs2_val = bus.wb_data;
    else                                         w_rs2_val = r_rf[w_rs2];
  end

  assign w_y = w_is_op ? w_rs2_val : w_imm;

  // Illegal instructions only wait for output space, never for the scoreboard
  logic w_stall;
  logic w_space;
  logic w_in_ready;
  logic w_accept;
  logic w_issue;

  assign w_stall    = w_legal && (w_busy_eff[w_rs1] ||
                                  (w_is_op && w_busy_eff[w_rs2]) ||
                                  w_busy_eff[w_rd]);
  assign w_space    = !r_out_valid || bus.out_ready;
  assign w_in_ready = rst_n && !w_stall && w_space;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_issue    = w_accept && w_legal;

  always_comb begin
    w_set = '0;
    if (w_issue && (w_rd != '0)) w_set[w_rd] = 1'b1;
  end

  // Output operation register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_x      <= '0;
      r_out_y      <= '0;
      r_out_funct3 <= '0;
      r_out_funct7 <= '0;
      r_out_rd     <= '0;
      r_illegal    <= 1'b0;
    end else begin
      r_illegal <= w_accept && !w_legal;
      if (w_issue) begin
        r_out_valid  <= 1'b1;
        r_out_x      <= w_rs1_val;
        r_out_y      <= w_y;
        r_out_funct3 <= w_f3;
        r_out_funct7 <= w_f7;
        r_out_rd     <= w_rd;
      end else if (bus.out_ready) begin
        r_out_valid  <= 1'b0;
      end
    end
  end

  // Scoreboard: issue set takes priority over a same-cycle write-back clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= (r_busy & ~w_clr) | w_set;
  end

  // Register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) r_rf[i] <= '0;
    end else if (bus.wb_valid && (bus.wb_rd != '0)) begin
      r_rf[bus.wb_rd] <= bus.wb_data;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_x      = r_out_x;
  assign bus.out_y      = r_out_y;
  assign bus.out_funct3 = r_out_funct3;
  assign bus.out_funct7 = r_out_funct7;
  assign bus.out_rd     = r_out_rd;
  assign bus.illegal    = r_illegal;
endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  localparam logic [31:0] I_ADD3  = 32'h002081B3; // ADD  x3,x1,x2
  localparam logic [31:0] I_ADDI4 = 32'hFFF00213; // ADDI x4,x0,-1
  localparam logic [31:0] I_SUB5  = 32'h401182B3; // SUB  x5,x3,x1
  localparam logic [31:0] I_ADD6  = 32'h00208333; // ADD  x6,x1,x2
  localparam logic [31:0] I_SRAI7 = 32'h4030D393; // SRAI x7,x1,3
  localparam logic [31:0] I_BADSL = 32'h40309393; // SLLI with funct7 0100000
  localparam logic [31:0] I_LW    = 32'h00002083; // LW   x1,0(x0)

  alu_issue_if bus ();

  alu_issue u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = '0;
    bus.wb_data   = '0;

    // Reset state
    #3;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_illegal",   32'(bus.illegal),   32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst_out_x",     bus.out_x,          32'd0);
    chk("rst_out_rd",    32'(bus.out_rd),    32'd0);
    #9 rst_n = 1'b1;
    step();

    // x1=5, x2=3
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'd5;
    step();
    bus.wb_rd = 5'd2; bus.wb_data = 32'd3;
    step();
    bus.wb_valid = 1'b0;

    // ADD x3,x1,x2
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = I_ADD3;
    #1 chk("add_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    chk("add_valid",  32'(bus.out_valid),  32'd1);
    chk("add_x",      bus.out_x,           32'd5);
    chk("add_y",      bus.out_y,           32'd3);
    chk("add_funct3", 32'(bus.out_funct3), 32'd0);
    chk("add_funct7", 32'(bus.out_funct7), 32'd0);
    chk("add_rd",     32'(bus.out_rd),     32'd3);

    // ADDI x4,x0,-1 back-to-back; concurrent write to x0 must be ignored
    bus.in_instr = I_ADDI4;
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hDEADBEEF;
    #1 chk("addi_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    bus.wb_valid = 1'b0;
    chk("addi_valid",  32'(bus.out_valid),  32'd1);
    chk("addi_x",      bus.out_x,           32'd0);
    chk("addi_y",      bus.out_y,           32'hFFFFFFFF);
    chk("addi_funct7", 32'(bus.out_funct7), 32'd0);
    chk("addi_rd",     32'(bus.out_rd),     32'd4);
    step();
    chk("addi_drain", 32'(bus.out_valid), 32'd0);

    // SUB x5,x3,x1 stalls on busy x3 until its write-back
    bus.in_valid = 1'b1;
    bus.in_instr = I_SUB5;
    #1 chk("sub_stall0", 32'(bus.in_ready), 32'd0);
    step();
    chk("sub_stall1", 32'(bus.in_ready),  32'd0);
    chk("sub_noout",  32'(bus.out_valid), 32'd0);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'd7;
    #1 chk("sub_wb_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.wb_valid  = 1'b0;
    bus.in_instr  = I_ADD6;
    bus.out_ready = 1'b0;
    chk("sub_valid",  32'(bus.out_valid),  32'd1);
    chk("sub_x",      bus.out_x,           32'd7);
    chk("sub_y",      bus.out_y,           32'd5);
    chk("sub_funct3", 32'(bus.out_funct3), 32'd0);
    chk("sub_funct7", 32'(bus.out_funct7), 32'h20);
    chk("sub_rd",     32'(bus.out_rd),     32'd5);

    // Back-pressure: output held, nothing accepted
    #1 chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_valid",    32'(bus.out_valid),  32'd1);
      chk("hold_x",        bus.out_x,           32'd7);
      chk("hold_y",        bus.out_y,           32'd5);
      chk("hold_funct7",   32'(bus.out_funct7), 32'h20);
      chk("hold_rd",       32'(bus.out_rd),     32'd5);
      chk("hold_in_ready", 32'(bus.in_ready),   32'd0);
    end
    bus.out_ready = 1'b1;
    #1 chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("add6_valid", 32'(bus.out_valid), 32'd1);
    chk("add6_x",     bus.out_x,          32'd5);
    chk("add6_y",     bus.out_y,          32'd3);
    chk("add6_rd",    32'(bus.out_rd),    32'd6);
    step();
    chk("add6_drain", 32'(bus.out_valid), 32'd0);

    // SRAI x7,x1,3: OP-IMM shift carrying funct7 0100000
    bus.in_valid = 1'b1;
    bus.in_instr = I_SRAI7;
    #1 chk("srai_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    chk("srai_valid",  32'(bus.out_valid),  32'd1);
    chk("srai_x",      bus.out_x,           32'd5);
    chk("srai_y",      bus.out_y,           32'h403);
    chk("srai_funct3", 32'(bus.out_funct3), 32'd5);
    chk("srai_funct7", 32'(bus.out_funct7), 32'h20);
    chk("srai_rd",     32'(bus.out_rd),     32'd7);

    // SLLI with non-zero funct7 is illegal; SRAI drains meanwhile
    bus.in_instr = I_BADSL;
    #1 chk("badsl_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("badsl_illegal", 32'(bus.illegal),   32'd1);
    chk("badsl_noout",   32'(bus.out_valid), 32'd0);

    // LW: illegal opcode, single-cycle pulse
    bus.in_valid = 1'b1;
    bus.in_instr = I_LW;
    #1 chk("lw_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("lw_illegal",  32'(bus.illegal),   32'd1);
    chk("lw_noout",    32'(bus.out_valid), 32'd0);
    chk("lw_in_ready2", 32'(bus.in_ready), 32'd1);
    step();
    chk("lw_pulse_end", 32'(bus.illegal),   32'd0);
    chk("lw_noout2",    32'(bus.out_valid), 32'd0);

    // Asynchronous reset with a pending output and x3 busy
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = I_ADD3;
    step();
    bus.in_valid = 1'b0;
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    chk("pre_rst_rd",    32'(bus.out_rd),    32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid",    32'(bus.out_valid), 32'd0);
    chk("arst_x",        bus.out_x,          32'd0);
    chk("arst_y",        bus.out_y,          32'd0);
    chk("arst_rd",       32'(bus.out_rd),    32'd0);
    chk("arst_in_ready", 32'(bus.in_ready),  32'd0);
    #2 rst_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_instr = I_SUB5;
    #1 chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("post_rst_valid",  32'(bus.out_valid),  32'd1);
    chk("post_rst_x",      bus.out_x,           32'd0);
    chk("post_rst_y",      bus.out_y,           32'd0);
    chk("post_rst_funct7", 32'(bus.out_funct7), 32'h20);
    chk("post_rst_rd",     32'(bus.out_rd),     32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
